div_arbiter: RTL and testbench

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_arbiter.sv | 130 +++++++++++++
 tb/tb_div_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// Round-robin front end that lets NUM_REQ requesters share one fixed-point divider.
// Divide-by-zero requests are answered locally and never start the divider.
module div_arbiter #(
    parameter int N       = 22,
    parameter int Q       = 10,
    parameter int NUM_REQ = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*N-1:0] req_dividend,
    input  logic [NUM_REQ*N-1:0] req_divisor,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [N-1:0]         rsp_q,
    output logic                 rsp_dbz,
    output logic                 rsp_overflow,
    output logic                 div_start,
    output logic [N-1:0]         div_dividend,
    output logic [N-1:0]         div_divisor,
    input  logic                 div_busy,
    input  logic                 div_done,
    input  logic                 div_overflow,
    input  logic [N-1:0]         div_q
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

    state_t           state;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand_idx;
    logic             grant_hit;
    int unsigned      cand;
    logic [N-1:0]     sel_dividend;
    logic [N-1:0]     sel_divisor;

    if (Q < 0 || Q >= N) begin : g_bad_q
        $error("div_arbiter: Q must lie in [0, N-1]");
    end

    // Scan starts one past the last winner so every requester gets a turn.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand     = (32'(last_grant) + 32'(k) + 32'd1) % 32'(NUM_REQ);
            cand_idx = IDX_W'(cand);
            if (!grant_hit && req_valid[cand_idx]) begin
                grant_hit = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && grant_hit)
            req_ready[grant_idx] = 1'b1;
    end

    assign sel_dividend = req_dividend[grant_idx*N +: N];
    assign sel_divisor  = req_divisor[grant_idx*N +: N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= IDX_W'(NUM_REQ - 1);
            owner        <= '0;
            rsp_valid    <= '0;
            rsp_q        <= '0;
            rsp_dbz      <= 1'b0;
            rsp_overflow <= 1'b0;
            div_start    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
        end else begin
            div_start <= 1'b0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (grant_hit) begin
                        div_dividend <= sel_dividend;
                        div_divisor  <= sel_divisor;
                        last_grant   <= grant_idx;
                        owner        <= grant_idx;
                        // Registered start lands in the ISSUE cycle itself.
                        div_start    <= (sel_divisor != '0);
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (div_divisor == '0) begin
                        rsp_q            <= '0;
                        rsp_dbz          <= 1'b1;
                        rsp_overflow     <= 1'b0;
                        rsp_valid[owner] <= 1'b1;
                        state            <= RESP;
                    end else begin
                        state <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    // div_done may still be high from the previous operation.
                    if (div_busy)
                        state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (div_done) begin
                        rsp_q            <= div_q;
                        rsp_overflow     <= div_overflow;
                        rsp_dbz          <= 1'b0;
                        rsp_valid[owner] <= 1'b1;
                        state            <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a small behavioural divider that keeps
// div_done high until it next goes busy.
`timescale 1ns/1ps
module tb_div_arbiter;
    localparam int N  = 22;
    localparam int Q  = 10;
    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*N-1:0] req_dividend;
    logic [NR*N-1:0] req_divisor;
    logic [NR-1:0]   rsp_valid;
    logic [N-1:0]    rsp_q;
    logic            rsp_dbz;
    logic            rsp_overflow;
    logic            div_start;
    logic [N-1:0]    div_dividend;
    logic [N-1:0]    div_divisor;
    logic            div_busy;
    logic            div_done;
    logic            div_overflow;
    logic [N-1:0]    div_q;

    int checks = 0;
    int errors = 0;
    int busy_len = 3;
    int phase;
    int cnt;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;

    always #5 clk = ~clk;

    div_arbiter #(.N(N), .Q(Q), .NUM_REQ(NR)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .rsp_valid(rsp_valid), .rsp_q(rsp_q), .rsp_dbz(rsp_dbz), .rsp_overflow(rsp_overflow),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_busy(div_busy), .div_done(div_done), .div_overflow(div_overflow), .div_q(div_q)
    );

    function automatic logic [N:0] fx_div(input logic [N-1:0] a, input logic [N-1:0] b);
        longint num;
        longint quo;
        longint lim;
        logic   ovf;
        if (b == '0) return '0;
        num = longint'($signed(a)) <<< Q;
        quo = num / longint'($signed(b));
        lim = 64'sd1 <<< (N - 1);
        ovf = (quo >= lim) || (quo < -lim);
        return {ovf, quo[N-1:0]};
    endfunction

    // Divider: goes busy two cycles after start, so stale done overlaps WAIT_BUSY.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_busy <= 1'b0; div_done <= 1'b0; div_q <= '0; div_overflow <= 1'b0;
            phase <= 0; cnt <= 0; op_a <= '0; op_b <= '0;
        end else if (div_start) begin
            op_a <= div_dividend; op_b <= div_divisor; phase <= 1;
        end else if (phase == 1) begin
            div_busy <= 1'b1; div_done <= 1'b0; cnt <= busy_len; phase <= 2;
        end else if (phase == 2) begin
            if (cnt <= 1) begin
                div_busy <= 1'b0; div_done <= 1'b1;
                {div_overflow, div_q} <= fx_div(op_a, op_b);
                phase <= 0;
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    task automatic issue(input logic [1:0] idx, input logic [N-1:0] a, input logic [N-1:0] b,
                         output bit ok);
        ok = 1'b0;
        req_dividend[idx*N +: N] = a;
        req_divisor[idx*N +: N]  = b;
        req_valid[idx] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (req_ready[idx]) begin
                @(posedge clk);
                #1;
                req_valid[idx] = 1'b0;
                req_dividend[idx*N +: N] = ~a;
                req_divisor[idx*N +: N]  = ~b;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) req_valid[idx] = 1'b0;
    endtask

    task automatic wait_rsp(input int limit, output bit got, output int n, output logic [NR-1:0] vec,
                            output int starts, output int start_n, output int done_n);
        bit saw_busy = 1'b0;
        got = 1'b0; n = 0; vec = '0; starts = 0; start_n = 0; done_n = 0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (div_start) begin
                starts++;
                if (start_n == 0) start_n = c;
            end
            if (div_busy) saw_busy = 1'b1;
            if (saw_busy && div_done && done_n == 0) done_n = c;
            if (rsp_valid != '0) begin
                got = 1'b1; n = c; vec = rsp_valid;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        req_valid = '1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== '0) begin
            errors++; $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        checks++;
        if ({rsp_valid, rsp_q, rsp_dbz, rsp_overflow, div_start, div_dividend, div_divisor} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rsp_valid=%b rsp_q=%h dbz=%b ovf=%b start=%b dvd=%h dvs=%h want all 0",
                     rsp_valid, rsp_q, rsp_dbz, rsp_overflow, div_start, div_dividend, div_divisor);
        end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== '0) begin
            errors++; $display("FAIL idle_ready: got %b want 0000", req_ready);
        end
        req_valid = 4'b1001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL reset_priority: got %b want 0001", req_ready);
        end
        req_valid = 4'b1010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL reset_priority2: got %b want 0010", req_ready);
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_single;
        bit ok, got; int n, starts, start_n, done_n; logic [NR-1:0] vec;
        busy_len = 3;
        issue(2'd1, 22'h000C00, 22'h000600, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_grant: got ok=%0d want 1", ok); end
        wait_rsp(60, got, n, vec, starts, start_n, done_n);
        checks++;
        if (!got || vec !== 4'b0010) begin
            errors++; $display("FAIL single_rsp_valid: got %b (got=%0d) want 0010", vec, got);
        end
        checks++;
        if (rsp_q !== 22'h000800 || rsp_dbz !== 1'b0 || rsp_overflow !== 1'b0) begin
            errors++; $display("FAIL single_result: q=%h dbz=%b ovf=%b want 000800 0 0", rsp_q, rsp_dbz, rsp_overflow);
        end
        checks++;
        if (starts != 1 || start_n != 1) begin
            errors++; $display("FAIL single_start: pulses=%0d at=%0d want 1 at 1", starts, start_n);
        end
        checks++;
        if (n != done_n + 1) begin
            errors++; $display("FAIL single_latency: rsp at %0d done at %0d want rsp=done+1", n, done_n);
        end
        checks++;
        if (div_dividend !== 22'h000C00 || div_divisor !== 22'h000600) begin
            errors++; $display("FAIL single_operand_hold: dvd=%h dvs=%h want 000c00 000600", div_dividend, div_divisor);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== '0 || rsp_q !== 22'h000800) begin
            errors++; $display("FAIL single_pulse_hold: rsp_valid=%b q=%h want 0000 000800", rsp_valid, rsp_q);
        end
    endtask

    task automatic test_dbz;
        bit ok, got; int n, starts, start_n, done_n; logic [NR-1:0] vec;
        issue(2'd2, 22'h001234, 22'h000000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL dbz_grant: got ok=%0d want 1", ok); end
        wait_rsp(20, got, n, vec, starts, start_n, done_n);
        checks++;
        if (!got || vec !== 4'b0100 || n != 2) begin
            errors++; $display("FAIL dbz_rsp: vec=%b at %0d want 0100 at 2", vec, n);
        end
        checks++;
        if (starts != 0) begin
            errors++; $display("FAIL dbz_no_start: pulses=%0d want 0", starts);
        end
        checks++;
        if (rsp_q !== '0 || rsp_dbz !== 1'b1 || rsp_overflow !== 1'b0) begin
            errors++; $display("FAIL dbz_flags: q=%h dbz=%b ovf=%b want 000000 1 0", rsp_q, rsp_dbz, rsp_overflow);
        end
        @(negedge clk);
    endtask

    task automatic test_overflow;
        bit ok, got; int n, starts, start_n, done_n; logic [NR-1:0] vec;
        issue(2'd0, 22'h0FA000, 22'h000001, ok);
        wait_rsp(60, got, n, vec, starts, start_n, done_n);
        checks++;
        if (!ok || !got || vec !== 4'b0001) begin
            errors++; $display("FAIL ovf_rsp: vec=%b ok=%0d want 0001", vec, ok);
        end
        checks++;
        if (rsp_overflow !== 1'b1 || rsp_dbz !== 1'b0) begin
            errors++; $display("FAIL ovf_flags: ovf=%b dbz=%b want 1 0", rsp_overflow, rsp_dbz);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        bit ok, got; int n, starts, start_n, done_n; logic [NR-1:0] vec;
        issue(2'd0, 22'h000C00, 22'h000600, ok);
        wait_rsp(60, got, n, vec, starts, start_n, done_n);
        checks++;
        if (!ok || !got || vec !== 4'b0001 || rsp_q !== 22'h000800) begin
            errors++; $display("FAIL b2b_first: vec=%b q=%h want 0001 000800", vec, rsp_q);
        end
        req_dividend[0 +: N] = 22'h000400;
        req_divisor[0 +: N]  = 22'h000800;
        req_valid[0] = 1'b1;
        #1;
        checks++;
        if (req_ready !== '0) begin
            errors++; $display("FAIL b2b_no_grant_in_resp: got %b want 0000", req_ready);
        end
        issue(2'd0, 22'h000400, 22'h000800, ok);
        wait_rsp(60, got, n, vec, starts, start_n, done_n);
        checks++;
        if (!ok || !got || vec !== 4'b0001 || starts != 1) begin
            errors++; $display("FAIL b2b_second_rsp: vec=%b starts=%0d want 0001 1", vec, starts);
        end
        checks++;
        if (rsp_q !== 22'h000200) begin
            errors++; $display("FAIL b2b_second_q: got %h want 000200", rsp_q);
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        int gcount = 0;
        int rcount = 0;
        int order [5] = '{0, 1, 2, 3, 0};
        logic [NR-1:0] grants [5];
        logic [NR-1:0] rsps [5];
        logic [N-1:0]  qs [5];
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < NR; i++) begin
            req_dividend[i*N +: N] = N'((i + 1) * 32'h400);
            req_divisor[i*N +: N]  = 22'h000400;
        end
        req_valid = '1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 300 && rcount < 5; c++) begin
            #1;
            if (rsp_valid != '0 && rcount < 5) begin
                rsps[rcount] = rsp_valid; qs[rcount] = rsp_q; rcount++;
            end
            if (req_ready != '0 && gcount < 5) begin
                grants[gcount] = req_ready; gcount++;
                if (gcount == 5) begin
                    @(posedge clk);
                    #1 req_valid = '0;
                end
            end
            @(negedge clk);
        end
        req_valid = '0;
        checks++;
        if (gcount != 5 || rcount != 5) begin
            errors++; $display("FAIL rr_counts: grants=%0d rsps=%0d want 5 5", gcount, rcount);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (grants[i] !== NR'(1 << order[i])) begin
                    errors++; $display("FAIL rr_grant%0d: got %b want %b", i, grants[i], NR'(1 << order[i]));
                end
                checks++;
                if (rsps[i] !== NR'(1 << order[i])) begin
                    errors++; $display("FAIL rr_rsp%0d: got %b want %b", i, rsps[i], NR'(1 << order[i]));
                end
                checks++;
                if (qs[i] !== N'((order[i] + 1) * 32'h400)) begin
                    errors++; $display("FAIL rr_q%0d: got %h want %h", i, qs[i], N'((order[i] + 1) * 32'h400));
                end
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_op;
        bit ok, got, seen, stray; int n, starts, start_n, done_n; logic [NR-1:0] vec;
        busy_len = 20;
        seen = 1'b0;
        stray = 1'b0;
        issue(2'd1, 22'h002000, 22'h000400, ok);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (div_busy) begin seen = 1'b1; break; end
        end
        checks++;
        if (!ok || !seen) begin
            errors++; $display("FAIL midrst_setup: ok=%0d busy_seen=%0d want 1 1", ok, seen);
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_q, rsp_dbz, rsp_overflow, div_start, div_dividend, div_divisor} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: ready=%b rsp_valid=%b q=%h dbz=%b ovf=%b start=%b dvd=%h dvs=%h want all 0",
                     req_ready, rsp_valid, rsp_q, rsp_dbz, rsp_overflow, div_start, div_dividend, div_divisor);
        end
        @(negedge clk);
        rst_n = 1'b1;
        busy_len = 3;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rsp_valid != '0) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++; $display("FAIL midrst_no_rsp: stray response seen=%0d want 0", stray);
        end
        issue(2'd3, 22'h000400, 22'h000400, ok);
        wait_rsp(60, got, n, vec, starts, start_n, done_n);
        checks++;
        if (!ok || !got || vec !== 4'b1000) begin
            errors++; $display("FAIL midrst_resume_rsp: vec=%b want 1000", vec);
        end
        checks++;
        if (rsp_q !== 22'h000400 || rsp_dbz !== 1'b0 || rsp_overflow !== 1'b0) begin
            errors++; $display("FAIL midrst_resume_q: q=%h dbz=%b ovf=%b want 000400 0 0", rsp_q, rsp_dbz, rsp_overflow);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        req_valid = '0;
        req_dividend = '0;
        req_divisor = '0;
        repeat (2) @(negedge clk);
        test_reset;
        test_single;
        test_dbz;
        test_overflow;
        test_back_to_back;
        test_round_robin;
        test_reset_mid_op;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
